// File: rtl/top_digital_24hr.sv
// 24-hour BCD time-of-day counter (HH:MM:SS), advancing one second per enabled clk edge.
// Seconds, minutes and hours stages cascade through carries that all resolve in the same edge.
module top_digital_24hr (
    input  logic       clk,
    input  logic       enable,
    input  logic       reset,
    output logic [3:0] ms_hr,
    output logic [3:0] ls_hr,
    output logic [3:0] ms_min,
    output logic [3:0] ls_min,
    output logic [3:0] ms_sec,
    output logic [3:0] ls_sec
);

    logic [3:0] msHr_q, lsHr_q, msMin_q, lsMin_q, msSec_q, lsSec_q;
    logic [3:0] msHr_d, lsHr_d, msMin_d, lsMin_d, msSec_d, lsSec_d;

    logic secUnitsWrap, secCarry, minUnitsWrap, minCarry, dayWrap;

    // Carries are qualified by enable so a held clock generates no ripple.
    always_comb begin
        secUnitsWrap = enable && (lsSec_q == 4'd9);
        secCarry     = secUnitsWrap && (msSec_q == 4'd5);
        minUnitsWrap = secCarry && (lsMin_q == 4'd9);
        minCarry     = minUnitsWrap && (msMin_q == 4'd5);
        dayWrap      = (msHr_q == 4'd2) && (lsHr_q == 4'd3);
    end

    always_comb begin
        msHr_d  = msHr_q;
        lsHr_d  = lsHr_q;
        msMin_d = msMin_q;
        lsMin_d = lsMin_q;
        msSec_d = msSec_q;
        lsSec_d = lsSec_q;

        if (enable) begin
            lsSec_d = secUnitsWrap ? 4'd0 : lsSec_q + 4'd1;
        end

        if (secUnitsWrap) begin
            msSec_d = (msSec_q == 4'd5) ? 4'd0 : msSec_q + 4'd1;
        end

        if (secCarry) begin
            lsMin_d = minUnitsWrap ? 4'd0 : lsMin_q + 4'd1;
        end

        if (minUnitsWrap) begin
            msMin_d = (msMin_q == 4'd5) ? 4'd0 : msMin_q + 4'd1;
        end

        // Hours count 00..23; the 23 -> 00 wrap takes priority over the units wrap.
        if (minCarry) begin
            if (dayWrap) begin
                msHr_d = 4'd0;
                lsHr_d = 4'd0;
            end else if (lsHr_q == 4'd9) begin
                msHr_d = msHr_q + 4'd1;
                lsHr_d = 4'd0;
            end else begin
                lsHr_d = lsHr_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msHr_q  <= 4'd0;
            lsHr_q  <= 4'd0;
            msMin_q <= 4'd0;
            lsMin_q <= 4'd0;
            msSec_q <= 4'd0;
            lsSec_q <= 4'd0;
        end else begin
            msHr_q  <= msHr_d;
            lsHr_q  <= lsHr_d;
            msMin_q <= msMin_d;
            lsMin_q <= lsMin_d;
            msSec_q <= msSec_d;
            lsSec_q <= lsSec_d;
        end
    end

    assign ms_hr  = msHr_q;
    assign ls_hr  = lsHr_q;
    assign ms_min = msMin_q;
    assign ls_min = lsMin_q;
    assign ms_sec = msSec_q;
    assign ls_sec = lsSec_q;

endmodule

// File: tb/tb_top_digital_24hr.sv
// Self-checking bench for top_digital_24hr: vector table, reset corner cases and a full-day run
// compared against a seconds-since-midnight reference model through an expected-value queue.
module tb_top_digital_24hr;

    logic       clk;
    logic       enable;
    logic       reset;
    logic [3:0] ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec;

    top_digital_24hr dut (
        .clk    (clk),
        .enable (enable),
        .reset  (reset),
        .ms_hr  (ms_hr),
        .ls_hr  (ls_hr),
        .ms_min (ms_min),
        .ls_min (ls_min),
        .ms_sec (ms_sec),
        .ls_sec (ls_sec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic en;
        int   expSec;
    } vec_t;

    vec_t vecs[16];
    int   expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   rangeErrors = 0;

    // Reference: seconds since midnight converted straight to six BCD digits.
    function automatic logic [23:0] toDigits(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic [23:0] dutDigits();
        return {ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec};
    endfunction

    task automatic compare(input string name, input logic [23:0] actual, input logic [23:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            if (mismatched <= 20)
                $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    // Drive enable on the falling edge and queue the time expected after the next rising edge.
    task automatic applyStimulus(input logic en, input int expSec);
        @(negedge clk);
        enable = en;
        expQ.push_back(expSec);
    endtask

    task automatic checkOutput(input string name);
        int e;
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: scoreboard empty, got %h, expected an entry", name, dutDigits());
        end else begin
            e = expQ.pop_front();
            compare(name, dutDigits(), toDigits(e));
        end
    endtask

    task automatic checkRange();
        if (ms_sec > 4'd5 || ls_sec > 4'd9 || ms_min > 4'd5 || ls_min > 4'd9 ||
            ms_hr > 4'd2 || ls_hr > 4'd9 || (ms_hr == 4'd2 && ls_hr > 4'd3))
            rangeErrors++;
    endtask

    initial begin
        for (int i = 0; i < 10; i++) vecs[i] = '{en: 1'b1, expSec: i + 1};
        for (int i = 10; i < 15; i++) vecs[i] = '{en: 1'b0, expSec: 10};
        vecs[15] = '{en: 1'b1, expSec: 11};

        enable = 1'b0;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compare("reset_state", dutDigits(), 24'h000000);
        @(negedge clk);
        reset = 1'b0;

        // Count to 00:00:10, hold five edges, then resume.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].en, vecs[i].expSec);
            checkOutput($sformatf("vec%0d", i));
        end

        for (int i = 12; i <= 15; i++) begin
            applyStimulus(1'b1, i);
            checkOutput($sformatf("pre_reset_%0d", i));
        end

        // Asynchronous reset mid-count must clear before any clock edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        compare("reset_async", dutDigits(), 24'h000000);
        @(posedge clk);
        #1;
        compare("reset_wins_over_enable", dutDigits(), 24'h000000);
        @(negedge clk);
        reset = 1'b0;
        expQ.push_back(1);
        checkOutput("first_after_release");

        // Full day from reset: every edge against the model, wrap back to midnight at the end.
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 86400; i++) begin
            applyStimulus(1'b1, (i + 1) % 86400);
            checkOutput($sformatf("day_edge_%0d", i + 1));
            checkRange();
        end
        compare("day_wrap_midnight", dutDigits(), 24'h000000);

        compared++;
        if (rangeErrors != 0) begin
            mismatched++;
            $display("[TB] FAIL bcd_range: got %0d out-of-range samples, expected 0", rangeErrors);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/top_digital_24hr.md
# top_digital_24hr

24-hour digital clock core that counts seconds, minutes and hours in BCD, advancing one second per enabled rising clock edge. It is driven by a 1 Hz timebase at the top of the clock/display subsystem. It presents six 4-bit BCD digits (HH:MM:SS) for downstream display decoding or monitoring.

## Interface

- No parameters; the 1 Hz tick rate, 24-hour range and BCD encoding are fixed.
- clk  input  1  system clock, one rising edge per second (1 Hz, 1 s period); port order is clk, enable, reset, then the digits listed below.
- reset  input  1  asynchronous, active-high; one clock; forces time to 00:00:00.
- enable  input  1  count enable, sampled on rising clk; 1 = advance one second, 0 = hold.
- ms_hr  output  4  hours tens digit, BCD 0–2.
- ls_hr  output  4  hours units digit, BCD 0–9 (0–3 when ms_hr = 2).
- ms_min  output  4  minutes tens digit, BCD 0–5.
- ls_min  output  4  minutes units digit, BCD 0–9.
- ms_sec  output  4  seconds tens digit, BCD 0–5.
- ls_sec  output  4  seconds units digit, BCD 0–9.

## Operation

- Six cascaded BCD digit counters. The recommended structure is a seconds stage, a minutes stage and an hours stage, each with a carry-out.
- ls_sec increments on every enabled edge. At 9 it wraps to 0 and carries to ms_sec.
- ms_sec wraps 5→0 when ls_sec = 9, producing the seconds carry (at xx:xx:59).
- ls_min increments on the seconds carry and wraps 9→0 with a carry to ms_min. ms_min wraps 5→0, producing the minutes carry (at xx:59:59).
- Hours increment on the minutes carry:
  - ls_hr wraps 9→0 with ms_hr+1 (09→10, 19→20).
  - When ms_hr = 2 and ls_hr = 3, both clear to 0 (23→00).
- Rollover 23:59:59 → 00:00:00 happens in a single edge. There is no day or overflow output.
- enable = 0: all digits hold, with no carries generated.
- reset = 1: all six digits clear to 0 immediately, regardless of clk and enable. This includes reset asserted mid-count or during a carry chain.
- Outputs never leave legal BCD ranges. Illegal states cannot occur from reset; no recovery logic is required.

## Timing

- All digit registers update on the rising edge of clk. Outputs are registered with no combinational path from inputs.
- Reset value of every output is 4'd0. Reset is asynchronous on assertion; release takes effect at the next rising edge.
- Latency: one enabled edge after the time reads T, the outputs read T+1 s. All cascaded carries resolve within that same edge (e.g. 09:59:59 → 10:00:00 in one cycle).
- After reset releases with enable = 1, the first rising edge yields 00:00:01. 86400 enabled edges return the clock to 00:00:00.
- If reset and enable are both high, reset wins.

## Test plan

- Reset: assert reset mid-count (e.g. at 12:34:56) → all digits 0 immediately, before the next clk edge. Release with enable = 1 → 00:00:01 after one edge.
- Seconds/minutes carry: from reset, 59 edges → 00:00:59; the next edge → 00:01:00. After 3599 edges → 00:59:59; the next edge → 01:00:00.
- Hour tens carry: after 35999 edges → 09:59:59; the next edge → 10:00:00. At 19:59:59 the next edge → 20:00:00.
- Day wrap: after 86399 edges → 23:59:59; the next edge → 00:00:00, never 24:00:00.
- Enable hold: at 00:00:10, drop enable for 5 edges → stays 00:00:10. Restore enable → 00:00:11 on the first edge.
- Range check: across a full 86400-edge run, every digit stays within its BCD range (seconds/minutes tens ≤ 5, hours ≤ 23).
